tree_walk_ctrl: RTL and testbench

- Depth-first traversal controller for the classification tree.
- Accepts one packet header at a time and seeds the node-ID stack with the root.
- Repeatedly pops a node, fetches it from node memory, and pushes the children of matching internal nodes.
- Reports the highest-priority (lowest rule_id) matching leaf.
- Sits between the packet ingress and the node memory/comparator, and owns the node-ID `stack` instance.

---
 rtl/tree_pkg.sv | 28 ++
 rtl/tree_walk_ctrl_if.sv | 40 ++++
 rtl/tree_walk_ctrl_stack.sv | 72 +++++++
 rtl/tree_walk_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_tree_walk_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tree_pkg.sv
// Shared types for the classification-tree walker.
// Width defaults, node response bundle, walk FSM states.
package tree_pkg;

  localparam int DEF_NODE_ID_W = 16;
  localparam int DEF_RULE_ID_W = 16;
  localparam int DEF_CHILD_W   = 4;

  typedef struct packed {
    logic                     is_leaf;
    logic                     match;
    logic [DEF_RULE_ID_W-1:0] rule;
    logic [DEF_NODE_ID_W-1:0] first_child;
    logic [DEF_CHILD_W-1:0]   num_children;
  } node_rsp_t;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    POP,
    POP_WAIT,
    FETCH,
    RSP_WAIT,
    PUSH_CHILD,
    DONE
  } walk_state_t;

endpackage

// File: rtl/tree_walk_ctrl_if.sv
// Node memory read bus between walker and node store.
// master = walker, slave = node memory / comparator.
interface tree_walk_ctrl_if #(
  parameter int NODE_ID_W = tree_pkg::DEF_NODE_ID_W,
  parameter int RULE_ID_W = tree_pkg::DEF_RULE_ID_W,
  parameter int CHILD_W   = tree_pkg::DEF_CHILD_W
) ();

  logic                 node_req;
  logic [NODE_ID_W-1:0] node_addr;
  logic                 node_rsp_valid;
  logic                 node_is_leaf;
  logic                 node_match;
  logic [RULE_ID_W-1:0] node_rule;
  logic [NODE_ID_W-1:0] node_first_child;
  logic [CHILD_W-1:0]   node_num_children;

  modport master (
    output node_req,
    output node_addr,
    input  node_rsp_valid,
    input  node_is_leaf,
    input  node_match,
    input  node_rule,
    input  node_first_child,
    input  node_num_children
  );

  modport slave (
    input  node_req,
    input  node_addr,
    output node_rsp_valid,
    output node_is_leaf,
    output node_match,
    output node_rule,
    output node_first_child,
    output node_num_children
  );

endinterface

// File: rtl/tree_walk_ctrl_stack.sv
// Node-ID LIFO; popped word appears one cycle after pop.
// Push while full / pop while empty are dropped.
module stack #(
  parameter int STACK_SIZE = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  just_popped,
  output logic                  empty,
  output logic                  full
);

  localparam int CW = $clog2(STACK_SIZE + 1);
  localparam int AW = (STACK_SIZE > 1) ?
                      $clog2(STACK_SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem_q [STACK_SIZE];
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  jp_q, jp_d;
  logic [CW-1:0]         top;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(STACK_SIZE));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full && !pop;
  assign top     = count_q - CW'(1);

  assign data_out    = dout_q;
  assign just_popped = jp_q;

  // pointer and read-register update
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    jp_d    = 1'b0;
    if (do_pop) begin
      count_d = top;
      dout_d  = mem_q[top[AW-1:0]];
      jp_d    = 1'b1;
    end else if (do_push) begin
      count_d = count_q + CW'(1);
    end
  end

  // pointer and read-register state
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      dout_q  <= '0;
      jp_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      jp_q    <= jp_d;
    end
  end

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[count_q[AW-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/tree_walk_ctrl.sv
// Depth-first classification-tree walker; lowest matching rule wins.
// Optional: TREE_WALK_VISIT_COUNT_EN adds visit_count output.
module tree_walk_ctrl
  import tree_pkg::*;
#(
  parameter int NODE_ID_W   = DEF_NODE_ID_W,
  parameter int RULE_ID_W   = DEF_RULE_ID_W,
  parameter int CHILD_W     = DEF_CHILD_W,
  parameter int STACK_DEPTH = 64,
  parameter int PKT_W       = 104
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic [PKT_W-1:0]     pkt_data,
  output logic [PKT_W-1:0]     pkt_hold,
  tree_walk_ctrl_if.master     mem,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 result_hit,
  output logic [RULE_ID_W-1:0] result_rule,
  output logic                 result_overflow,
  output logic                 busy
`ifdef TREE_WALK_VISIT_COUNT_EN
  ,
  output logic [15:0]          visit_count
`endif
);

  walk_state_t          state_q, state_d;
  logic [PKT_W-1:0]     hold_q, hold_d;
  logic [NODE_ID_W-1:0] node_id_q, node_id_d;
  logic [NODE_ID_W-1:0] fc_q, fc_d;
  logic [CHILD_W-1:0]   cnt_q, cnt_d;
  logic [RULE_ID_W-1:0] best_q, best_d;
  logic                 hit_q, hit_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 req;
  logic                 stk_rst;
  logic                 stk_push, stk_pop;
  logic [NODE_ID_W-1:0] stk_din, stk_dout;
  logic                 stk_jp, stk_empty, stk_full;
  logic [CHILD_W-1:0]   child_idx;

  assign accept    = (state_q == IDLE) && pkt_valid;
  assign stk_rst   = reset || accept;
  assign child_idx = cnt_q - CHILD_W'(1);

  assign pkt_ready       = (state_q == IDLE);
  assign pkt_hold        = hold_q;
  assign mem.node_req    = req;
  assign mem.node_addr   = node_id_q;
  assign result_valid    = (state_q == DONE);
  assign result_hit      = hit_q;
  assign result_rule     = best_q;
  assign result_overflow = ovf_q;
  assign busy            = (state_q != IDLE) &&
                           (state_q != DONE);

  stack #(
    .STACK_SIZE (STACK_DEPTH),
    .DATA_WIDTH (NODE_ID_W)
  ) u_stack (
    .clk         (clk),
    .reset       (stk_rst),
    .push        (stk_push),
    .pop         (stk_pop),
    .data_in     (stk_din),
    .data_out    (stk_dout),
    .just_popped (stk_jp),
    .empty       (stk_empty),
    .full        (stk_full)
  );

  // walk sequencing, stack control and best-rule tracking
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    node_id_d = node_id_q;
    fc_d      = fc_q;
    cnt_d     = cnt_q;
    best_d    = best_q;
    hit_d     = hit_q;
    ovf_d     = ovf_q;
    req       = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_din   = '0;
    unique case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          hold_d  = pkt_data;
          best_d  = '0;
          hit_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = SEED;
        end
      end
      SEED: begin
        stk_push = 1'b1;
        stk_din  = '0;
        state_d  = POP;
      end
      POP: begin
        if (stk_empty) begin
          state_d = DONE;
        end else begin
          stk_pop = 1'b1;
          state_d = POP_WAIT;
        end
      end
      POP_WAIT: begin
        if (stk_jp) begin
          node_id_d = stk_dout;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        req     = 1'b1;
        state_d = RSP_WAIT;
      end
      RSP_WAIT: begin
        if (mem.node_rsp_valid) begin
          state_d = POP;
          if (mem.node_match) begin
            if (mem.node_is_leaf) begin
              if (!hit_q ||
                  mem.node_rule < best_q) begin
                best_d = mem.node_rule;
                hit_d  = 1'b1;
              end
            end else if (
                mem.node_num_children != '0) begin
              fc_d    = mem.node_first_child;
              cnt_d   = mem.node_num_children;
              state_d = PUSH_CHILD;
            end
          end
        end
      end
      PUSH_CHILD: begin
        // highest child first so the lowest pops first
        if (stk_full) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          stk_push = 1'b1;
          stk_din  = fc_q + NODE_ID_W'(child_idx);
          cnt_d    = child_idx;
          if (cnt_q == CHILD_W'(1)) begin
            state_d = POP;
          end
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // walk state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      node_id_q <= '0;
      fc_q      <= '0;
      cnt_q     <= '0;
      best_q    <= '0;
      hit_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      node_id_q <= node_id_d;
      fc_q      <= fc_d;
      cnt_q     <= cnt_d;
      best_q    <= best_d;
      hit_q     <= hit_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef TREE_WALK_VISIT_COUNT_EN
  logic [15:0] visit_q, visit_d;

  assign visit_count = visit_q;

  // saturating count of node reads for this packet
  always_comb begin
    visit_d = visit_q;
    if (accept) begin
      visit_d = '0;
    end else if (req && visit_q != 16'hFFFF) begin
      visit_d = visit_q + 16'd1;
    end
  end

  // visit counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      visit_q <= '0;
    end else begin
      visit_q <= visit_d;
    end
  end
`endif

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Directed bench for tree_walk_ctrl: two instances,
// depth 64 for traversal cases, depth 2 for overflow.
module tb_tree_walk_ctrl;
  import tree_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  logic         pkt_valid = 1'b0;
  logic         pkt_ready;
  logic [103:0] pkt_data = '0;
  logic [103:0] pkt_hold;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic         result_hit;
  logic [15:0]  result_rule;
  logic         result_overflow;
  logic         busy;

  logic         pkt2_valid = 1'b0;
  logic         pkt2_ready;
  logic [103:0] pkt2_data = '0;
  logic [103:0] pkt2_hold;
  logic         res2_valid;
  logic         res2_ready = 1'b0;
  logic         res2_hit;
  logic [15:0]  res2_rule;
  logic         res2_ovf;
  logic         busy2;
`ifdef TREE_WALK_VISIT_COUNT_EN
  logic [15:0]  visit_count;
  logic [15:0]  visit_count2;
`endif

  tree_walk_ctrl_if #(
    .NODE_ID_W(16), .RULE_ID_W(16), .CHILD_W(4)
  ) m_if ();
  tree_walk_ctrl_if #(
    .NODE_ID_W(16), .RULE_ID_W(16), .CHILD_W(4)
  ) m2_if ();

  tree_walk_ctrl #(.STACK_DEPTH(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .pkt_valid       (pkt_valid),
    .pkt_ready       (pkt_ready),
    .pkt_data        (pkt_data),
    .pkt_hold        (pkt_hold),
    .mem             (m_if),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_hit      (result_hit),
    .result_rule     (result_rule),
    .result_overflow (result_overflow),
    .busy            (busy)
`ifdef TREE_WALK_VISIT_COUNT_EN
    ,
    .visit_count     (visit_count)
`endif
  );

  tree_walk_ctrl #(.STACK_DEPTH(2)) dut2 (
    .clk             (clk),
    .reset           (reset),
    .pkt_valid       (pkt2_valid),
    .pkt_ready       (pkt2_ready),
    .pkt_data        (pkt2_data),
    .pkt_hold        (pkt2_hold),
    .mem             (m2_if),
    .result_valid    (res2_valid),
    .result_ready    (res2_ready),
    .result_hit      (res2_hit),
    .result_rule     (res2_rule),
    .result_overflow (res2_ovf),
    .busy            (busy2)
`ifdef TREE_WALK_VISIT_COUNT_EN
    ,
    .visit_count     (visit_count2)
`endif
  );

  // node memory model for dut, programmable latency
  node_rsp_t   mem_tab [16];
  int          mem_lat = 0;
  logic        rsp_v   = 1'b0;
  logic        p_on    = 1'b0;
  int          p_cnt   = 0;
  logic [15:0] p_addr  = '0;
  int          reads[$];

  always @(posedge clk) begin
    rsp_v <= 1'b0;
    if (m_if.node_req) begin
      reads.push_back(int'(m_if.node_addr));
      p_addr <= m_if.node_addr;
      if (mem_lat == 0) begin
        rsp_v <= 1'b1;
      end else begin
        p_on  <= 1'b1;
        p_cnt <= mem_lat - 1;
      end
    end else if (p_on) begin
      if (p_cnt == 0) begin
        rsp_v <= 1'b1;
        p_on  <= 1'b0;
      end else begin
        p_cnt <= p_cnt - 1;
      end
    end
  end

  assign m_if.node_rsp_valid    = rsp_v;
  assign m_if.node_is_leaf      = mem_tab[p_addr[3:0]].is_leaf;
  assign m_if.node_match        = mem_tab[p_addr[3:0]].match;
  assign m_if.node_rule         = mem_tab[p_addr[3:0]].rule;
  assign m_if.node_first_child  =
    mem_tab[p_addr[3:0]].first_child;
  assign m_if.node_num_children =
    mem_tab[p_addr[3:0]].num_children;

  // fixed tree for dut2: root with 4 children
  logic        rsp2_v  = 1'b0;
  logic [15:0] p2_addr = '0;
  int          reads2  = 0;
  int          push_full = 0;

  always @(posedge clk) begin
    rsp2_v <= m2_if.node_req;
    if (m2_if.node_req) begin
      p2_addr <= m2_if.node_addr;
      reads2  <= reads2 + 1;
    end
    if (dut2.u_stack.push && dut2.u_stack.full) begin
      push_full <= push_full + 1;
    end
  end

  assign m2_if.node_rsp_valid    = rsp2_v;
  assign m2_if.node_is_leaf      = (p2_addr != 16'd0);
  assign m2_if.node_match        = (p2_addr == 16'd0);
  assign m2_if.node_rule         = 16'd1;
  assign m2_if.node_first_child  = 16'd1;
  assign m2_if.node_num_children =
    (p2_addr == 16'd0) ? 4'd4 : 4'd0;

  function automatic node_rsp_t mk(
    input logic leaf, input logic m,
    input logic [15:0] rule,
    input logic [15:0] fc, input logic [3:0] nc);
    node_rsp_t r;
    r.is_leaf      = leaf;
    r.match        = m;
    r.rule         = rule;
    r.first_child  = fc;
    r.num_children = nc;
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n = edges from the accept edge to result_valid
  task automatic run_pkt(input logic [103:0] d,
                         output int n);
    pkt_data  = d;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    n = 1;
    while (!result_valid && n < 400) begin
      tick();
      n++;
    end
    chk("done_seen", result_valid, 1);
  endtask

  task automatic ack();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  localparam logic [103:0] D1 =
    104'h01020304_05060708_090A0B0C_0D;
  localparam logic [103:0] D2 =
    104'hA5A5A5A5_5A5A5A5A_DEADBEEF_77;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    for (int i = 0; i < 16; i++)
      mem_tab[i] = mk(1'b1, 1'b0, 16'd0, 16'd0, 4'd0);

    repeat (3) tick();
    chk("rst_pkt_ready", pkt_ready, 1);
    chk("rst_res_valid", result_valid, 0);
    chk("rst_hit", result_hit, 0);
    chk("rst_rule", result_rule, 0);
    chk("rst_ovf", result_overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hold", pkt_hold, 0);
    chk("rst_req", m_if.node_req, 0);
    reset = 1'b0;
    tick();

    // root leaf, rule 7, 1-cycle memory
    mem_tab[0] = mk(1'b1, 1'b1, 16'd7, 16'd0, 4'd0);
    mem_lat = 0;
    reads.delete();
    run_pkt(D1, n);
    chk("leaf_lat", n, 7);
    chk("leaf_hit", result_hit, 1);
    chk("leaf_rule", result_rule, 7);
    chk("leaf_ovf", result_overflow, 0);
    chk("leaf_busy", busy, 0);
    chk("leaf_hold", pkt_hold, D1);
    chk("leaf_reads", reads.size(), 1);
    ack();
    chk("leaf_ack_rdy", pkt_ready, 1);

    // root with 3 children, rules 9, 4, none
    mem_tab[0] = mk(1'b0, 1'b1, 16'd0, 16'd1, 4'd3);
    mem_tab[1] = mk(1'b1, 1'b1, 16'd9, 16'd0, 4'd0);
    mem_tab[2] = mk(1'b1, 1'b1, 16'd4, 16'd0, 4'd0);
    mem_tab[3] = mk(1'b1, 1'b0, 16'd2, 16'd0, 4'd0);
    mem_lat = 2;
    reads.delete();
    run_pkt(D2, n);
    chk("tree_nreads", reads.size(), 4);
    for (int i = 0; i < 4; i++) begin
      k = (reads.size() > i) ? reads[i] : -1;
      chk($sformatf("tree_read%0d", i), k, i);
    end
    chk("tree_hit", result_hit, 1);
    chk("tree_rule", result_rule, 4);
    chk("tree_ovf", result_overflow, 0);
    chk("tree_hold", pkt_hold, D2);
`ifdef TREE_WALK_VISIT_COUNT_EN
    chk("tree_visits", visit_count, 4);
`endif
    ack();

    // no child matches
    mem_tab[1] = mk(1'b1, 1'b0, 16'd9, 16'd0, 4'd0);
    mem_tab[2] = mk(1'b1, 1'b0, 16'd4, 16'd0, 4'd0);
    mem_lat = 0;
    reads.delete();
    run_pkt(D1, n);
    chk("miss_nreads", reads.size(), 4);
    chk("miss_hit", result_hit, 0);
    chk("miss_rule", result_rule, 0);
    chk("miss_ovf", result_overflow, 0);
    ack();

    // depth-2 stack, root with 4 children
    chk("ovf_rdy", pkt2_ready, 1);
    pkt2_data  = D2;
    pkt2_valid = 1'b1;
    tick();
    pkt2_valid = 1'b0;
    k = 0;
    while (!res2_valid && k < 200) begin
      tick();
      k++;
    end
    chk("ovf_done", res2_valid, 1);
    chk("ovf_flag", res2_ovf, 1);
    chk("ovf_hit", res2_hit, 0);
    chk("ovf_rule", res2_rule, 0);
    chk("ovf_reads", reads2, 1);
    chk("ovf_push_full", push_full, 0);
    chk("ovf_busy", busy2, 0);
    chk("ovf_hold", pkt2_hold, D2);
    res2_ready = 1'b1;
    tick();
    res2_ready = 1'b0;
    chk("ovf_ack_rdy", pkt2_ready, 1);

    // reset while waiting for a slow response
    mem_tab[0] = mk(1'b1, 1'b1, 16'd5, 16'd0, 4'd0);
    mem_lat = 5;
    reads.delete();
    pkt_data  = D2;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    k = 0;
    while (reads.size() == 0 && k < 50) begin
      tick();
      k++;
    end
    chk("mid_req_seen", reads.size(), 1);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_rdy", pkt_ready, 1);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", pkt_hold, 0);
    repeat (8) tick();
    chk("late_rsp_busy", busy, 0);
    chk("late_rsp_valid", result_valid, 0);
    chk("late_rsp_rdy", pkt_ready, 1);
    mem_tab[0] = mk(1'b1, 1'b1, 16'd3, 16'd0, 4'd0);
    mem_lat = 0;
    run_pkt(D1, n);
    chk("post_rst_lat", n, 7);
    chk("post_rst_hit", result_hit, 1);
    chk("post_rst_rule", result_rule, 3);
    ack();

    // result held while consumer stalls
    mem_tab[0] = mk(1'b1, 1'b1, 16'd7, 16'd0, 4'd0);
    run_pkt(D2, n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", result_valid, 1);
      chk("hold_hit", result_hit, 1);
      chk("hold_rule", result_rule, 7);
      chk("hold_ovf", result_overflow, 0);
      chk("hold_rdy", pkt_ready, 0);
    end
    ack();
    chk("hold_ack_valid", result_valid, 0);
    chk("hold_ack_rdy", pkt_ready, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
